// File: rtl/sy_pkg.sv
// Shared types and defaults for the APB master arbiter.
package sy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

  localparam int APB_ARB_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/apb_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N_MST.
module apb_rr_pick #(
  parameter int N_MST = 2
) (
  input  logic [N_MST-1:0]         req,
  input  logic [$clog2(N_MST)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_MST)-1:0] idx
);

  localparam int IW = $clog2(N_MST);

  logic [2*N_MST-1:0] req2;
  logic [N_MST-1:0]   rot;
  logic [IW-1:0]      off;
  logic [IW:0]        sum;

  // Rotate so that bit 0 of rot is the master at ptr.
  assign req2 = {req, req} >> ptr;
  assign rot  = req2[N_MST-1:0];

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    off = '0;
    for (int i = N_MST - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
  end

  assign valid = |req;
  assign sum   = {1'b0, ptr} + {1'b0, off};
  assign idx   = (sum >= (IW+1)'(N_MST)) ? IW'(sum - (IW+1)'(N_MST)) : sum[IW-1:0];

endmodule

// File: rtl/apb_mst_arb.sv
// Round-robin arbiter sharing one downstream APB port among N_MST upstream masters,
// with registered downstream fields and a forced-error timeout for hung slaves.
module apb_mst_arb
  import sy_pkg::*;
#(
  parameter int N_MST          = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = APB_ARB_TIMEOUT_DEFAULT
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [N_MST-1:0]                         m_psel_i,
  input  logic [N_MST-1:0]                         m_penable_i,
  input  logic [N_MST-1:0]                         m_pwrite_i,
  input  logic [N_MST-1:0][APB_ADDR_WIDTH-1:0]     m_paddr_i,
  input  logic [N_MST-1:0][APB_DATA_WIDTH-1:0]     m_pwdata_i,
  output logic [N_MST-1:0][APB_DATA_WIDTH-1:0]     m_prdata_o,
  output logic [N_MST-1:0]                         m_pready_o,
  output logic [N_MST-1:0]                         m_pslverr_o,
  output logic                                     psel_o,
  output logic                                     penable_o,
  output logic                                     pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]                paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]                prdata_i,
  input  logic                                     pready_i,
  input  logic                                     pslverr_i,
  output logic                                     timeout_o
);

  localparam int IW      = $clog2(N_MST);
  localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  apb_arb_state_e state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, gnt_q, pick_idx, gnt_next;
  logic           pick_valid;
  logic [CW-1:0]  cnt_q;
  logic           timeout_hit, done;
  logic           unused_penable;

  // Upstream enables carry no information for the arbiter; the setup/access sequence is regenerated.
  assign unused_penable = ^m_penable_i;

  apb_rr_pick #(.N_MST(N_MST)) u_pick (
    .req   (m_psel_i),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !pready_i
                       && (cnt_q == CW'(TO_LAST));
  assign done        = (state_q == ACCESS) && (pready_i || timeout_hit);
  assign timeout_o   = timeout_hit;
  assign gnt_next    = (gnt_q == IW'(N_MST - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = SETUP;
      SETUP:   state_d = m_psel_i[gnt_q] ? ACCESS : IDLE;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
    end else begin
      state_q   <= state_d;
      psel_o    <= (state_d != IDLE);
      penable_o <= (state_d == ACCESS);
      if (state_q == IDLE && pick_valid) begin
        gnt_q    <= pick_idx;
        pwrite_o <= m_pwrite_i[pick_idx];
        paddr_o  <= m_paddr_i[pick_idx];
        pwdata_o <= m_pwdata_i[pick_idx];
      end
      if (done) rr_ptr_q <= gnt_next;
      if (state_q == ACCESS && !done && TIMEOUT != 0) cnt_q <= cnt_q + 1'b1;
      else                                            cnt_q <= '0;
    end
  end

  // Response is routed combinationally to the granted master only.
  always_comb begin
    m_pready_o  = '0;
    m_pslverr_o = '0;
    m_prdata_o  = '0;
    if (done) begin
      m_pready_o[gnt_q]  = 1'b1;
      m_pslverr_o[gnt_q] = timeout_hit | pslverr_i;
      m_prdata_o[gnt_q]  = timeout_hit ? '0 : prdata_i;
    end
  end

endmodule

// File: tb/tb_apb_mst_arb.sv
// Directed bench for apb_mst_arb: two masters, TIMEOUT=8, hand-computed expectations.
module tb_apb_mst_arb;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [1:0]        m_psel_i, m_penable_i, m_pwrite_i;
  logic [1:0][31:0]  m_paddr_i, m_pwdata_i, m_prdata_o;
  logic [1:0]        m_pready_o, m_pslverr_o;
  logic              psel_o, penable_o, pwrite_o, timeout_o;
  logic [31:0]       paddr_o, pwdata_o, prdata_i;
  logic              pready_i, pslverr_i;

  int n_assert = 0;
  int n_fail   = 0;

  apb_mst_arb #(
    .N_MST(2), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_psel_i(m_psel_i), .m_penable_i(m_penable_i), .m_pwrite_i(m_pwrite_i),
    .m_paddr_i(m_paddr_i), .m_pwdata_i(m_pwdata_i),
    .m_prdata_o(m_prdata_o), .m_pready_o(m_pready_o), .m_pslverr_o(m_pslverr_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    m_psel_i = '0; m_penable_i = '0; m_pwrite_i = '0;
    m_paddr_i = '0; m_pwdata_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_psel",    64'(psel_o), 64'(0));
    check("rst_penable", 64'(penable_o), 64'(0));
    check("rst_pwrite",  64'(pwrite_o), 64'(0));
    check("rst_paddr",   64'(paddr_o), 64'(0));
    check("rst_pwdata",  64'(pwdata_o), 64'(0));
    check("rst_mready",  64'(m_pready_o), 64'(0));
    check("rst_timeout", 64'(timeout_o), 64'(0));

    // Single read from master 1.
    next_cycle();
    m_psel_i = 2'b10; m_paddr_i[1] = 32'h1000;
    @(negedge clk_i);
    check("t1_idle_psel", 64'(psel_o), 64'(0));
    next_cycle();
    @(negedge clk_i);
    check("t1_setup_psel",    64'(psel_o), 64'(1));
    check("t1_setup_penable", 64'(penable_o), 64'(0));
    check("t1_setup_paddr",   64'(paddr_o), 64'h1000);
    check("t1_setup_mready",  64'(m_pready_o), 64'(0));
    next_cycle();
    pready_i = 1'b1; prdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    check("t1_acc_penable", 64'(penable_o), 64'(1));
    check("t1_acc_mready",  64'(m_pready_o), 64'(2'b10));
    check("t1_prdata1",     64'(m_prdata_o[1]), 64'hDEADBEEF);
    check("t1_prdata0",     64'(m_prdata_o[0]), 64'(0));
    check("t1_slverr",      64'(m_pslverr_o), 64'(0));
    next_cycle();
    m_psel_i = '0; pready_i = 1'b0; prdata_i = '0;
    @(negedge clk_i);
    check("t1_end_psel",   64'(psel_o), 64'(0));
    check("t1_end_mready", 64'(m_pready_o), 64'(0));

    // Both masters request continuously: grants alternate 0,1,0,1.
    next_cycle();
    m_psel_i = 2'b11; m_paddr_i[0] = 32'hA0; m_paddr_i[1] = 32'hB0; pready_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk_i);
      check("t2_idle_psel", 64'(psel_o), 64'(0));
      next_cycle();
      @(negedge clk_i);
      check("t2_setup_paddr", 64'(paddr_o), (t % 2 == 1) ? 64'hB0 : 64'hA0);
      next_cycle();
      @(negedge clk_i);
      check("t2_acc_mready", 64'(m_pready_o), (t % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
      next_cycle();
    end
    m_psel_i = '0; pready_i = 1'b0;
    @(negedge clk_i);
    check("t2_end_psel", 64'(psel_o), 64'(0));

    // Write from master 0 with five wait states, then error response.
    next_cycle();
    m_psel_i = 2'b01; m_pwrite_i = 2'b01; m_paddr_i[0] = 32'h44; m_pwdata_i[0] = 32'h12345678;
    next_cycle();
    @(negedge clk_i);
    check("t3_setup_psel",   64'(psel_o), 64'(1));
    check("t3_setup_pwrite", 64'(pwrite_o), 64'(1));
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      m_paddr_i[0] = 32'hFFFF0000 + 32'(i); m_pwdata_i[0] = 32'hA5A50000 + 32'(i);
      @(negedge clk_i);
      check("t3_wait_paddr",   64'(paddr_o), 64'h44);
      check("t3_wait_pwdata",  64'(pwdata_o), 64'h12345678);
      check("t3_wait_mready",  64'(m_pready_o), 64'(0));
      check("t3_wait_slverr",  64'(m_pslverr_o), 64'(0));
      check("t3_wait_penable", 64'(penable_o), 64'(1));
    end
    next_cycle();
    pready_i = 1'b1; pslverr_i = 1'b1;
    @(negedge clk_i);
    check("t3_done_mready", 64'(m_pready_o), 64'(2'b01));
    check("t3_done_slverr", 64'(m_pslverr_o), 64'(2'b01));
    check("t3_done_paddr",  64'(paddr_o), 64'h44);
    next_cycle();
    m_psel_i = '0; m_pwrite_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    @(negedge clk_i);
    check("t3_end_slverr", 64'(m_pslverr_o), 64'(0));
    check("t3_end_psel",   64'(psel_o), 64'(0));

    // Slave never ready: timeout after 8 ACCESS cycles.
    next_cycle();
    m_psel_i = 2'b10; m_paddr_i[1] = 32'h2000; prdata_i = 32'h55AA55AA;
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      @(negedge clk_i);
      check("t4_wait_timeout", 64'(timeout_o), 64'(0));
      check("t4_wait_mready",  64'(m_pready_o), 64'(0));
    end
    next_cycle();
    @(negedge clk_i);
    check("t4_hit_timeout", 64'(timeout_o), 64'(1));
    check("t4_hit_mready",  64'(m_pready_o), 64'(2'b10));
    check("t4_hit_slverr",  64'(m_pslverr_o), 64'(2'b10));
    check("t4_hit_prdata",  64'(m_prdata_o[1]), 64'(0));
    next_cycle();
    m_psel_i = '0; prdata_i = '0;
    @(negedge clk_i);
    check("t4_end_psel",    64'(psel_o), 64'(0));
    check("t4_end_timeout", 64'(timeout_o), 64'(0));

    // Address change during SETUP is ignored.
    next_cycle();
    m_psel_i = 2'b01; m_paddr_i[0] = 32'h10;
    next_cycle();
    m_paddr_i[0] = 32'h20;
    @(negedge clk_i);
    check("t5_setup_paddr", 64'(paddr_o), 64'h10);
    next_cycle();
    pready_i = 1'b1;
    @(negedge clk_i);
    check("t5_acc_paddr",  64'(paddr_o), 64'h10);
    check("t5_acc_mready", 64'(m_pready_o), 64'(2'b01));
    next_cycle();
    m_psel_i = '0; pready_i = 1'b0;

    // Master 1 drops psel in SETUP: no access phase.
    next_cycle();
    m_psel_i = 2'b10; m_paddr_i[1] = 32'h30;
    next_cycle();
    m_psel_i = '0;
    @(negedge clk_i);
    check("t6_setup_psel",    64'(psel_o), 64'(1));
    check("t6_setup_penable", 64'(penable_o), 64'(0));
    next_cycle();
    @(negedge clk_i);
    check("t6_drop_psel",    64'(psel_o), 64'(0));
    check("t6_drop_penable", 64'(penable_o), 64'(0));
    next_cycle();
    @(negedge clk_i);
    check("t6_idle_penable", 64'(penable_o), 64'(0));

    // Reset during ACCESS; rr_ptr (1 before reset) must return to 0.
    next_cycle();
    m_psel_i = 2'b01; m_paddr_i[0] = 32'h40; m_paddr_i[1] = 32'h50;
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    check("t7_acc_penable", 64'(penable_o), 64'(1));
    rst_i = 1'b1; m_psel_i = 2'b11;
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t7_rst_psel",    64'(psel_o), 64'(0));
    check("t7_rst_penable", 64'(penable_o), 64'(0));
    check("t7_rst_paddr",   64'(paddr_o), 64'(0));
    check("t7_rst_mready",  64'(m_pready_o), 64'(0));
    next_cycle();
    @(negedge clk_i);
    check("t7_rr_psel",  64'(psel_o), 64'(1));
    check("t7_rr_paddr", 64'(paddr_o), 64'h40);
    next_cycle();
    pready_i = 1'b1;
    @(negedge clk_i);
    check("t7_rr_mready", 64'(m_pready_o), 64'(2'b01));
    next_cycle();
    m_psel_i = '0; pready_i = 1'b0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
